ram_loader: RTL and testbench

// - Upstream program-loading stage for the 8-bit bus computer. Replaces hierarchical RAM pokes.
// - Accepts a byte stream from a host link and writes each byte into program RAM through the

---
 rtl/ram_loader_if.sv | 16 +
 rtl/ram_loader.sv | 114 +++++++++++
 tb/tb_ram_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ram_loader_if.sv
// Host byte stream plus RAM write port for the program loader.
// The loader takes the slave side; the host/RAM environment takes the master side.
interface ram_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;

  modport master (output in_valid, in_data, input in_ready, ram_addr, ram_data, ram_we);
  modport slave  (input in_valid, in_data, output in_ready, ram_addr, ram_data, ram_we);
endinterface

// File: rtl/ram_loader.sv
// Frame loader: HDR{base,len_m1}, LEN data bytes, CSUM. Writes RAM with one cycle
// of latency and holds the computer in clear until the frame checksum passes.
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  ram_loader_if.slave   bus,
  output logic          cpu_clr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_REL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, waddr_q, waddr_d;
  logic [DATA_W-1:0] sum_q, sum_d, wdata_q, wdata_d;
  logic              we_q, we_d, clr_d, busy_d, done_d, err_d;
  logic              xfer;

  assign bus.in_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = waddr_q;
  assign bus.ram_data = wdata_q;
  assign xfer         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cpu_clr <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cpu_clr <= clr_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    clr_d   = cpu_clr;
    busy_d  = busy;
    done_d  = done;
    err_d   = err;
    case (state_q)
      S_IDLE: if (start) begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        clr_d   = 1'b1;
        state_d = S_HDR;
      end
      S_HDR: if (xfer) begin
        ptr_d   = bus.in_data[2*ADDR_W-1:ADDR_W];
        cnt_d   = bus.in_data[ADDR_W-1:0];
        sum_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        // cnt counts down from len_m1; zero means this is the last data byte
        we_d    = 1'b1;
        waddr_d = ptr_q;
        wdata_d = bus.in_data;
        ptr_d   = ptr_q + ADDR_W'(1);
        sum_d   = sum_q + bus.in_data;
        if (cnt_q == '0) state_d = S_CSUM;
        else             cnt_d   = cnt_q - ADDR_W'(1);
      end
      S_CSUM: if (xfer) begin
        if (bus.in_data == sum_q) begin
          state_d = S_REL;
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_REL: begin
        clr_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: directed frames plus random frames, scored against
// an expected write list and status derived from the frame rules.
module tb_ram_loader;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic start = 1'b0;
  logic cpu_clr, busy, done, err;

  ram_loader_if #(.ADDR_W(4), .DATA_W(8)) bus();

  ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .bus    (bus.slave),
    .cpu_clr(cpu_clr),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] wlog[$];
  logic [11:0] exp_q[$];

  always @(negedge clk) if (bus.ram_we) wlog.push_back({bus.ram_addr, bus.ram_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte until accepted; returns 1 time unit after the transfer edge.
  task automatic send(input logic [7:0] b, input bit stall);
    int n;
    logic rdy;
    if (stall) while ($urandom_range(0, 2) == 0) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 40) begin
        chk("xfer_timeout", 1, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input logic [3:0] base, input logic [3:0] lm1, input logic [7:0] d[16],
                       input bit bad, input bit stall, input bit ign);
    logic [7:0] s;
    int n;
    s = 8'h00;
    wlog.delete();
    exp_q.delete();
    for (int i = 0; i <= int'(lm1); i++) begin
      s = s + d[i];
      exp_q.push_back({4'(int'(base) + i), d[i]});
    end
    pulse_start();
    chk("arm_busy", busy, 1);
    chk("arm_clr", cpu_clr, 1);
    send({base, lm1}, stall);
    for (int i = 0; i <= int'(lm1); i++) begin
      send(d[i], stall);
      if (ign && i == 0) pulse_start();
    end
    send(bad ? 8'(s + 8'($urandom_range(1, 255))) : s, stall);
    if (bad) begin
      chk("bad_err", err, 1);
      chk("bad_done", done, 0);
      chk("bad_busy", busy, 0);
      chk("bad_clr", cpu_clr, 1);
    end else begin
      chk("rel_done", done, 0);
      chk("rel_clr", cpu_clr, 1);
      @(posedge clk); #1;
      chk("ok_done", done, 1);
      chk("ok_clr", cpu_clr, 0);
      chk("ok_busy", busy, 0);
      chk("ok_err", err, 0);
    end
    chk("wr_count", wlog.size(), exp_q.size());
    n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("wr_entry", wlog[i], exp_q[i]);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, bus.in_ready, 0);
    chk({tag, "_we"}, bus.ram_we, 0);
    chk({tag, "_addr"}, bus.ram_addr, 0);
    chk({tag, "_data"}, bus.ram_data, 0);
    chk({tag, "_clr"}, cpu_clr, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  logic [7:0] basic[16];
  logic [7:0] d[16];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    foreach (basic[i]) basic[i] = 8'h00;
    basic[0] = 8'h1E; basic[1] = 8'h2F; basic[2] = 8'hE0; basic[3] = 8'hF0;

    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", bus.in_ready, 0);

    // basic load, wrap, bad checksum, stalls, ignored start
    frame(4'h0, 4'h3, basic, 1'b0, 1'b0, 1'b0);
    foreach (d[i]) d[i] = 8'h00;
    d[0] = 8'h38; d[1] = 8'h23; d[2] = 8'h01;
    frame(4'hE, 4'h2, d, 1'b0, 1'b0, 1'b0);
    d[0] = 8'h55;
    frame(4'h0, 4'h0, d, 1'b1, 1'b0, 1'b0);
    frame(4'h0, 4'h3, basic, 1'b0, 1'b1, 1'b0);
    frame(4'h0, 4'h3, basic, 1'b0, 1'b0, 1'b1);

    // reset two data bytes into a frame; the pending second write must not appear
    wlog.delete();
    pulse_start();
    send(8'h03, 1'b0);
    send(8'h1E, 1'b0);
    send(8'h2F, 1'b0);
    clr_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wr_count", wlog.size(), 1);
    clr_n = 1'b1;
    @(posedge clk); #1;
    frame(4'h0, 4'h3, basic, 1'b0, 1'b0, 1'b0);

    // random frames
    repeat (10) begin
      foreach (d[i]) d[i] = 8'($urandom);
      frame(4'($urandom), 4'($urandom), d, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
